// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (data over instruction) arbiter for a shared memory
//            port with a per-transaction acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch requester (read-only)
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen during the TIMEOUT-th busy cycle.
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [31:0]       r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  logic w_busy;
  logic w_timeout;
  logic w_done;

  assign w_busy    = (r_state != IDLE);
  // An acknowledge in the final allowed cycle beats the timeout.
  assign w_timeout = w_busy && !mem_ack && (r_waitCnt == C_LAST);
  assign w_done    = w_busy && (mem_ack || w_timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req) begin
            r_state   <= DBUSY;
            r_waitCnt <= '0;
            r_addr    <= d_addr;
            r_we      <= d_we;
            r_be      <= d_be;
            r_wdata   <= d_wdata;
          end else if (i_req) begin
            r_state   <= IBUSY;
            r_waitCnt <= '0;
            r_addr    <= i_addr;
            r_we      <= 1'b0;
            r_be      <= 4'hF;
            r_wdata   <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (w_done) begin
            r_state <= IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign i_ready = (r_state == IBUSY) && w_done;
  assign d_ready = (r_state == DBUSY) && w_done;
  assign i_rdata = ((r_state == IBUSY) && mem_ack) ? mem_rdata : '0;
  assign d_rdata = ((r_state == DBUSY) && mem_ack) ? mem_rdata : '0;
  assign bus_err = w_timeout;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack before aborting a transaction.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req input 1, i_addr input 32, i_rdata output 32, i_ready output 1 for the instruction-fetch requester (read-only).
REQ-005 SHALL have ports d_req input 1, d_we input 1, d_be input 4, d_addr input 32, d_wdata input 32, d_rdata output 32, d_ready output 1 for the data-memory requester.
REQ-006 SHALL have ports mem_req output 1, mem_we output 1, mem_be output 4, mem_addr output 32, mem_wdata output 32, mem_rdata input 32, mem_ack input 1 for the single shared memory port.
REQ-007 SHALL have port bus_err  output  1  one-cycle pulse on transaction timeout.

Function
REQ-008 SHALL implement FSM states IDLE, IBUSY, DBUSY.
REQ-009 IDLE: at rising edge, d_req=1 -> DBUSY; else i_req=1 -> IBUSY; else stay IDLE (fixed data priority).
REQ-010 On grant edge SHALL register address, we, be, wdata of granted requester (i side: mem_we=0, mem_be=4'hF, mem_wdata=0).
REQ-011 mem_req SHALL be 1 exactly while state is IBUSY or DBUSY; mem_addr/we/be/wdata SHALL come from the registered fields only and be stable for the whole transaction.
REQ-012 In xBUSY with mem_ack=1: x_ready=1 combinationally in that same cycle, x_rdata=mem_rdata in that cycle, next state IDLE.
REQ-013 x_ready SHALL be 0 in every other cycle; x_rdata SHALL be 0 when x_ready=0.
REQ-014 Minimum transaction = 2 cycles (IDLE grant cycle + one BUSY cycle); always one IDLE cycle between transactions, so a requester still holding req at its ready edge is not regranted on that edge.
REQ-015 Requester drop of x_req during xBUSY SHALL be ignored; transaction completes and x_ready still pulses.
REQ-016 mem_ack while IDLE SHALL be ignored (no ready, no state change).
REQ-017 Wait counter SHALL clear on grant, increment each BUSY cycle without mem_ack; reaching TIMEOUT with mem_ack=0 -> bus_err=1 and x_ready=1 with x_rdata=0 in that cycle, next state IDLE.
REQ-018 mem_ack and timeout in the same cycle: ack wins, bus_err=0, normal completion.
REQ-019 Counter width SHALL be clog2(TIMEOUT+1); no wrap-around reachable.
REQ-020 Simultaneous d_req and i_req in IDLE: data granted; instruction granted at next IDLE if i_req still 1.

Reset
REQ-021 rst=0 SHALL immediately force state IDLE, wait counter 0, registered fields 0, hence mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0, i_rdata=d_rdata=0, bus_err=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it with no ready pulse; first grant after release evaluated at first rising edge with rst=1.

Verification
REQ-023 Single fetch: i_req=1, i_addr=32'h0000_0040, mem_ack next cycle with mem_rdata=32'h2008_0005 -> mem_req 1 cycle, mem_addr=32'h40, i_ready=1, i_rdata=32'h2008_0005.
REQ-024 Contention: i_req and d_req high together, d_we=1, d_addr=32'h10, d_wdata=32'hDEAD_BEEF, ack after 3 wait cycles -> data served first (mem_we=1, mem_be=4'hF), one IDLE cycle, then fetch granted.
REQ-025 Timeout: TIMEOUT=4, d_req read, mem_ack never -> after 4 BUSY cycles bus_err=1, d_ready=1, d_rdata=0, then IDLE.
REQ-026 Ack-vs-timeout: TIMEOUT=4, mem_ack=1 on the 4th BUSY cycle with rdata=32'h1234 -> d_ready=1, d_rdata=32'h1234, bus_err=0.
REQ-027 Reset mid-op: assert rst=0 during DBUSY -> mem_req=0 immediately, no d_ready; release with i_req=1 -> fetch granted at first edge.
REQ-028 Stray/withdrawn: mem_ack pulses while IDLE -> no ready; i_req dropped during IBUSY -> i_ready still pulses on ack.
